// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA sync timing plus solid/bars/checker/gradient pixel stage with frame-shadowed controls
module vga_pattern_gen #(
  parameter int   COLOR_W     = 4,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   CHECK_SHIFT = 5,
  parameter int   GRAD_SHIFT  = 5,
  localparam int  H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW          = $clog2(H_TOTAL),
  localparam int  YW          = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] color,
  output logic [3*COLOR_W-1:0] rgb,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 video_on,
  output logic                 frame_start,
  output logic [XW-1:0]        pos_x,
  output logic [YW-1:0]        pos_y
);
  localparam int CW3  = 3 * COLOR_W;
  localparam int BW   = H_ACTIVE / 8;
  localparam int GMAX = 2 ** COLOR_W - 1;
  localparam logic [COLOR_W-1:0] ZC = '0;
  logic [XW-1:0]      h_cnt;
  logic [YW-1:0]      v_cnt;
  logic [1:0]         mode_s;
  logic [CW3-1:0]     color_s;
  logic               h_last, v_last, act, hs_on, vs_on, cb;
  logic [2:0]         b;
  logic [31:0]        gx;
  logic [COLOR_W-1:0] g, r_s, g_s, b_s;
  logic [CW3-1:0]     pix;
  assign h_last = h_cnt == XW'(H_TOTAL - 1);
  assign v_last = v_cnt == YW'(V_TOTAL - 1);
  assign act    = (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
  assign hs_on  = (h_cnt >= XW'(H_ACTIVE + H_FP)) && (h_cnt <= XW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_on  = (v_cnt >= YW'(V_ACTIVE + V_FP)) && (v_cnt <= YW'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign cb     = |(((32'(h_cnt) >> CHECK_SHIFT) ^ (32'(v_cnt) >> CHECK_SHIFT)) & 32'd1);
  assign gx     = 32'(h_cnt) >> GRAD_SHIFT;
  assign g      = (gx > 32'(GMAX)) ? COLOR_W'(GMAX) : gx[COLOR_W-1:0];
  assign r_s    = color_s[CW3-1 -: COLOR_W];
  assign g_s    = color_s[2*COLOR_W-1 -: COLOR_W];
  assign b_s    = color_s[COLOR_W-1:0];
  // Bar index by threshold comparison: the last threshold passed wins
  always_comb begin
    b = '0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= XW'(k * BW)) b = 3'(k);
  end
  // Pixel colour for the current counter position, before blanking
  always_comb begin
    pix = mode_s == 2'd0 ? color_s :
          mode_s == 2'd1 ? {{COLOR_W{~b[1]}}, {COLOR_W{~b[2]}}, {COLOR_W{~b[0]}}} :
          mode_s == 2'd2 ? (cb ? ~color_s : color_s) :
          {(|r_s ? g : ZC), (|g_s ? g : ZC), (|b_s ? g : ZC)};
  end
  // Stage 0: horizontal and vertical raster counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end
  end
  // Shadow mode/colour on the last raster position so a new frame starts clean
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_s  <= '0;
      color_s <= '0;
    end else if (h_last && v_last) begin
      mode_s  <= mode;
      color_s <= color;
    end
  end
  // Stage 1: register every output from the same counter snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb         <= '0;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
    end else begin
      rgb         <= act ? pix : '0;
      h_sync      <= hs_on ? SYNC_POL : ~SYNC_POL;
      v_sync      <= vs_on ? SYNC_POL : ~SYNC_POL;
      video_on    <= act;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      pos_x       <= h_cnt;
      pos_y       <= v_cnt;
    end
  end
endmodule
